psr_cc_unit: RTL and testbench

//   Clocked successor to the latch-style condition register. Holds the LC-3 PSR (PRIV, PRI, N/Z/P),

---
 rtl/lc3_pkg.sv | 19 +
 rtl/psr_stack.sv | 57 +++++
 rtl/psr_cc_unit.sv | 142 ++++++++++++++
 tb/tb_psr_cc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// LC-3 PSR field positions and condition-code encodings shared by the
// condition-code unit and its saved-PSR stack.
package lc3_pkg;

    localparam int unsigned PRIV_BIT = 15;
    localparam int unsigned PRI_LSB  = 8;
    localparam int unsigned CC_LSB   = 0;

    typedef enum logic [2:0] {
        CC_P = 3'b001,
        CC_Z = 3'b010,
        CC_N = 3'b100
    } cc_e;

    function automatic logic cc_is_legal(input logic [2:0] cc);
        return (cc == CC_N) || (cc == CC_Z) || (cc == CC_P);
    endfunction

endpackage

// File: rtl/psr_stack.sv
// Parametrised LIFO holding saved PSR images; only the occupancy pointer
// is reset, so entries left behind by a reset can never be read back.
module psr_stack #(
    parameter int unsigned DW    = 7,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_idx, top_idx;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !push_i && !empty_o;

    assign wr_idx  = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - CW'(1));
    assign rdata_o = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push)
            cnt_d = cnt_q + CW'(1);
        else if (do_pop)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_idx] <= wdata_i;
    end

endmodule

// File: rtl/psr_cc_unit.sv
// LC-3 processor status register: N/Z/P classification, BR condition test,
// and PSR save/restore across interrupt entry and RTI.
module psr_cc_unit
    import lc3_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned PRI_W       = 3
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [WIDTH-1:0]                   D_IN,
    input  logic                               LD_CC,
    input  logic                               LD_PSR,
    input  logic [15:0]                        PSR_IN,
    input  logic                               PUSH,
    input  logic [PRI_W-1:0]                   PUSH_PRI,
    input  logic                               POP,
    input  logic [2:0]                         BR_NZP,
    input  logic                               ERR_CLR,
    output logic                               N,
    output logic                               Z,
    output logic                               P,
    output logic                               PRIV,
    output logic [PRI_W-1:0]                   PRI,
    output logic [15:0]                        PSR_OUT,
    output logic                               BR_TAKEN,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   DEPTH,
    output logic                               OVF,
    output logic                               UNF
);

    localparam int unsigned CW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned SDW = 1 + PRI_W + 3;

    logic             priv_q, priv_d;
    logic [PRI_W-1:0] pri_q, pri_d;
    logic [2:0]       cc_q, cc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [2:0]       d_cc;
    logic             stk_full, stk_empty;
    logic [SDW-1:0]   stk_rdata;
    logic             pop_priv;
    logic [PRI_W-1:0] pop_pri;
    logic [2:0]       pop_cc;
    logic             both;
    logic             unused_psr_bits;

    assign unused_psr_bits = ^{PSR_IN[14:PRI_LSB+PRI_W], PSR_IN[7:3]};

    always_comb begin
        if (D_IN == '0)
            d_cc = CC_Z;
        else if (D_IN[WIDTH-1])
            d_cc = CC_N;
        else
            d_cc = CC_P;
    end

    assign both = PUSH && POP;

    psr_stack #(
        .DW    (SDW),
        .DEPTH (STACK_DEPTH),
        .CW    (CW)
    ) u_stack (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (PUSH && !POP),
        .pop_i   (POP && !PUSH),
        .wdata_i ({priv_q, pri_q, cc_q}),
        .rdata_o (stk_rdata),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .count_o (DEPTH)
    );

    assign {pop_priv, pop_pri, pop_cc} = stk_rdata;

    // POP > PUSH > LD_PSR > LD_CC; a blocked POP/PUSH still masks the lower strobes.
    always_comb begin
        priv_d = priv_q;
        pri_d  = pri_q;
        cc_d   = cc_q;
        if (both) begin
            priv_d = priv_q;
        end else if (POP) begin
            if (!stk_empty) begin
                priv_d = pop_priv;
                pri_d  = pop_pri;
                cc_d   = pop_cc;
            end
        end else if (PUSH) begin
            if (!stk_full) begin
                priv_d = 1'b0;
                pri_d  = PUSH_PRI;
            end
        end else if (LD_PSR) begin
            priv_d = PSR_IN[PRIV_BIT];
            pri_d  = PSR_IN[PRI_LSB +: PRI_W];
            cc_d   = cc_is_legal(PSR_IN[CC_LSB +: 3]) ? PSR_IN[CC_LSB +: 3] : CC_Z;
        end else if (LD_CC) begin
            cc_d = d_cc;
        end
    end

    assign ovf_d = (PUSH && (POP || stk_full)) || (ovf_q && !ERR_CLR);
    assign unf_d = (POP && (PUSH || stk_empty)) || (unf_q && !ERR_CLR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            priv_q <= 1'b0;
            pri_q  <= '0;
            cc_q   <= CC_Z;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            priv_q <= priv_d;
            pri_q  <= pri_d;
            cc_q   <= cc_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_comb begin
        PSR_OUT                   = '0;
        PSR_OUT[PRIV_BIT]         = priv_q;
        PSR_OUT[PRI_LSB +: PRI_W] = pri_q;
        PSR_OUT[CC_LSB +: 3]      = cc_q;
    end

    assign {N, Z, P} = cc_q;
    assign PRIV      = priv_q;
    assign PRI       = pri_q;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;
    assign BR_TAKEN  = |(BR_NZP & cc_q);

endmodule

// File: tb/tb_psr_cc_unit.sv
// Directed bench for psr_cc_unit: flag classification, BR test, PSR stack
// nesting, error flags and asynchronous reset mid-nesting.
module tb_psr_cc_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] D_IN;
    logic        LD_CC, LD_PSR, PUSH, POP, ERR_CLR;
    logic [15:0] PSR_IN;
    logic [2:0]  PUSH_PRI;
    logic [2:0]  BR_NZP;
    logic        N, Z, P, PRIV, BR_TAKEN, OVF, UNF;
    logic [2:0]  PRI;
    logic [15:0] PSR_OUT;
    logic [2:0]  DEPTH;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 CLK = ~CLK;

    psr_cc_unit #(
        .WIDTH       (16),
        .STACK_DEPTH (4),
        .PRI_W       (3)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .D_IN     (D_IN),
        .LD_CC    (LD_CC),
        .LD_PSR   (LD_PSR),
        .PSR_IN   (PSR_IN),
        .PUSH     (PUSH),
        .PUSH_PRI (PUSH_PRI),
        .POP      (POP),
        .BR_NZP   (BR_NZP),
        .ERR_CLR  (ERR_CLR),
        .N        (N),
        .Z        (Z),
        .P        (P),
        .PRIV     (PRIV),
        .PRI      (PRI),
        .PSR_OUT  (PSR_OUT),
        .BR_TAKEN (BR_TAKEN),
        .DEPTH    (DEPTH),
        .OVF      (OVF),
        .UNF      (UNF)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Strobes set by the caller are captured on the next rising edge, then dropped.
    task automatic tick();
        @(posedge CLK);
        #1;
        LD_CC = 0; LD_PSR = 0; PUSH = 0; POP = 0; ERR_CLR = 0;
        @(negedge CLK);
    endtask

    task automatic check_state(input string tag, input logic [15:0] psr, input logic [2:0] depth,
                               input logic ovf, input logic unf);
        check_eq({tag, ".psr"}, {16'h0, PSR_OUT}, {16'h0, psr});
        check_eq({tag, ".depth"}, {29'h0, DEPTH}, {29'h0, depth});
        check_eq({tag, ".err"}, {30'h0, OVF, UNF}, {30'h0, ovf, unf});
    endtask

    initial begin
        RST_N = 0; D_IN = '0; LD_CC = 0; LD_PSR = 0; PSR_IN = '0;
        PUSH = 0; PUSH_PRI = '0; POP = 0; BR_NZP = 3'b000; ERR_CLR = 0;
        #12;
        check_state("reset", 16'h0002, 3'd0, 1'b0, 1'b0);
        check_eq("reset.nzp", {29'h0, N, Z, P}, 32'h2);
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);

        // 1: classification and hold
        D_IN = 16'hF011; LD_CC = 1; tick();
        check_eq("cc.neg", {29'h0, N, Z, P}, 32'h4);
        D_IN = 16'h0111; LD_CC = 1; tick();
        check_eq("cc.pos", {29'h0, N, Z, P}, 32'h1);
        D_IN = 16'h0000; LD_CC = 1; tick();
        check_eq("cc.zero", {29'h0, N, Z, P}, 32'h2);
        D_IN = 16'hFFFF; tick();
        D_IN = 16'h1234; tick();
        check_eq("cc.hold", {29'h0, N, Z, P}, 32'h2);

        // 2: BR condition against NZP=001
        D_IN = 16'h0001; LD_CC = 1; tick();
        BR_NZP = 3'b011; #1;
        check_eq("br.011", {31'h0, BR_TAKEN}, 32'h1);
        BR_NZP = 3'b110; #1;
        check_eq("br.110", {31'h0, BR_TAKEN}, 32'h0);
        BR_NZP = 3'b000; #1;
        check_eq("br.000", {31'h0, BR_TAKEN}, 32'h0);
        @(negedge CLK);

        // 3: single interrupt entry / return
        PSR_IN = 16'h8001; LD_PSR = 1; tick();
        check_state("ldpsr", 16'h8001, 3'd0, 1'b0, 1'b0);
        PUSH_PRI = 3'd4; PUSH = 1; tick();
        check_state("push1", 16'h0401, 3'd1, 1'b0, 1'b0);
        D_IN = 16'h8000; LD_CC = 1; tick();
        check_eq("push1.ldcc", {16'h0, PSR_OUT}, 32'h0404);
        BR_NZP = 3'b100; #1;
        check_eq("push1.br", {31'h0, BR_TAKEN}, 32'h1);
        POP = 1; tick();
        check_state("pop1", 16'h8001, 3'd0, 1'b0, 1'b0);
        #1;
        check_eq("pop1.br", {31'h0, BR_TAKEN}, 32'h0);
        @(negedge CLK);

        // 4: fill to depth, overflow, drain in LIFO order, underflow
        PUSH_PRI = 3'd1; PUSH = 1; tick();
        PUSH_PRI = 3'd2; PUSH = 1; tick();
        D_IN = 16'h8000; LD_CC = 1; tick();
        PUSH_PRI = 3'd3; PUSH = 1; tick();
        PUSH_PRI = 3'd4; PUSH = 1; tick();
        check_state("fill4", 16'h0404, 3'd4, 1'b0, 1'b0);
        PUSH_PRI = 3'd7; PUSH = 1; tick();
        check_state("ovf", 16'h0404, 3'd4, 1'b1, 1'b0);
        POP = 1; tick();
        check_state("drain1", 16'h0304, 3'd3, 1'b1, 1'b0);
        POP = 1; tick();
        check_state("drain2", 16'h0204, 3'd2, 1'b1, 1'b0);
        POP = 1; tick();
        check_state("drain3", 16'h0101, 3'd1, 1'b1, 1'b0);
        POP = 1; tick();
        check_state("drain4", 16'h8001, 3'd0, 1'b1, 1'b0);
        POP = 1; tick();
        check_state("unf", 16'h8001, 3'd0, 1'b1, 1'b1);
        ERR_CLR = 1; tick();
        check_state("errclr", 16'h8001, 3'd0, 1'b0, 1'b0);
        ERR_CLR = 1; POP = 1; tick();
        check_state("setwins", 16'h8001, 3'd0, 1'b0, 1'b1);
        ERR_CLR = 1; tick();

        // 5: strobe arbitration and illegal CC
        PUSH_PRI = 3'd5; PUSH = 1; tick();
        check_state("push5", 16'h0501, 3'd1, 1'b0, 1'b0);
        PUSH_PRI = 3'd6; PUSH = 1; POP = 1; tick();
        check_state("pushpop", 16'h0501, 3'd1, 1'b1, 1'b1);
        ERR_CLR = 1; tick();
        D_IN = 16'h8000; POP = 1; LD_CC = 1; tick();
        check_state("pop_ldcc", 16'h8001, 3'd0, 1'b0, 1'b0);
        PSR_IN = 16'h0007; LD_PSR = 1; tick();
        check_eq("ldpsr.illegal", {16'h0, PSR_OUT}, 32'h0002);
        PSR_IN = 16'h8704; LD_PSR = 1; D_IN = 16'h0005; LD_CC = 1; tick();
        check_eq("ldpsr.over_ldcc", {16'h0, PSR_OUT}, 32'h8704);
        check_eq("ldpsr.fields", {27'h0, PRIV, PRI, 1'b0}, {27'h0, 1'b1, 3'd7, 1'b0});

        // 6: asynchronous reset at depth 3
        PUSH_PRI = 3'd1; PUSH = 1; tick();
        PUSH_PRI = 3'd2; PUSH = 1; tick();
        PUSH_PRI = 3'd3; PUSH = 1; tick();
        check_state("nest3", 16'h0304, 3'd3, 1'b0, 1'b0);
        RST_N = 0;
        #2;
        check_state("async_rst", 16'h0002, 3'd0, 1'b0, 1'b0);
        #2;
        RST_N = 1;
        @(negedge CLK);
        check_state("post_rst", 16'h0002, 3'd0, 1'b0, 1'b0);
        POP = 1; tick();
        check_state("post_rst.pop", 16'h0002, 3'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
